// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader.
//   state_e        : FSM encoding (IDLE, REQ, XFER, DONE)
//   *_DEF          : default BURST_LEN / DW / CW
//   STAT_W         : width of the statistics counters
package fifo_burst_rd_pkg;

    localparam int BURST_LEN_DEF = 8;
    localparam int DW_DEF        = 16;
    localparam int CW_DEF        = 128;
    localparam int STAT_W        = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Burst request / write-data handshake between the reader and the SDRAM controller.
//   burst_req      : reader -> controller, held until burst_ack
//   burst_ack      : controller -> reader, 1-cycle accept pulse
//   wr_burst_data  : reader -> controller, burst word
//   wr_burst_valid : reader -> controller, word valid
//   wr_burst_ready : controller -> reader, word accepted
// modport master = reader side, modport slave = controller side.
interface fifo_burst_reader_if
    import fifo_burst_rd_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic          burst_req;
    logic          burst_ack;
    logic [DW-1:0] wr_burst_data;
    logic          wr_burst_valid;
    logic          wr_burst_ready;

    modport master (
        output burst_req, wr_burst_data, wr_burst_valid,
        input  burst_ack, wr_burst_ready
    );

    modport slave (
        input  burst_req, wr_burst_data, wr_burst_valid,
        output burst_ack, wr_burst_ready
    );
endinterface

// File: rtl/fifo_burst_reader_rd_skid_buf.sv
// Two-entry skid buffer that absorbs the FIFO's one-cycle read latency.
//   clk, rst_n : clock, async active-low reset (empties the buffer)
//   push       : write push_data this cycle
//   pop        : retire head entry this cycle
//   head_data  : oldest entry
//   count      : occupancy 0..2
module rd_skid_buf
    import fifo_burst_rd_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side drain engine for the SDRAM write-path async FIFO. Waits for a full
// burst in the FIFO, requests an SDRAM write burst, pops BURST_LEN words and
// streams them out over valid/ready through a 2-entry skid buffer.
//   sys_clk1, sys_rst_n1 : read-domain clock, async active-low reset
//   fifo_empty, fifo_underrun, fifo_data_num, rd_data, rd_en : FIFO read port
//   bus (master)         : burst request + write-data handshake
//   busy                 : FSM not in IDLE
//   err_underrun         : sticky underrun flag, cleared only by reset
//   burst_cnt, stall_cnt : statistics
// Build option: define FIFO_BURST_RD_STAT_EN to make burst_cnt/stall_cnt live
// counters; otherwise both read as zero and no counter flops exist.
//
// state | meaning
// IDLE  | waiting for fifo_data_num >= BURST_LEN
// REQ   | burst_req high, waiting for burst_ack
// XFER  | popping FIFO and streaming BURST_LEN words
// DONE  | one cycle, burst completed
module fifo_burst_reader
    import fifo_burst_rd_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int DW        = DW_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic              sys_clk1,
    input  logic              sys_rst_n1,
    input  logic              fifo_empty,
    input  logic              fifo_underrun,
    input  logic [CW-1:0]     fifo_data_num,
    input  logic [DW-1:0]     rd_data,
    output logic              rd_en,
    fifo_burst_reader_if.master bus,
    output logic              busy,
    output logic              err_underrun,
    output logic [STAT_W-1:0] burst_cnt,
    output logic [STAT_W-1:0] stall_cnt
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] REQ  = ST_REQ;
    localparam logic [1:0] XFER = ST_XFER;
    localparam logic [1:0] DONE = ST_DONE;

    localparam int            PW     = $clog2(BURST_LEN + 1);
    localparam logic [PW-1:0] LAST   = PW'(BURST_LEN);
    localparam logic [CW-1:0] THRESH = CW'(BURST_LEN);

    logic [1:0]    state;
    logic [PW-1:0] popped;
    logic [PW-1:0] sent;
    logic          in_flight;
    logic [1:0]    skid_count;
    logic [DW-1:0] head_data;
    logic          out_valid;
    logic          xfer;
    logic [1:0]    occ_next;

    assign out_valid = (skid_count != 2'd0);
    assign xfer      = out_valid && bus.wr_burst_ready;

    // Occupancy after this cycle: buffered + word still arriving from the FIFO,
    // minus the word leaving now. Counting the departing word keeps the stream
    // at one word per cycle while ready is high.
    assign occ_next = skid_count + {1'b0, in_flight} - {1'b0, xfer};

    assign rd_en = (state == XFER) && (popped < LAST) && !fifo_empty && (occ_next < 2'd2);

    always_ff @(posedge sys_clk1 or negedge sys_rst_n1) begin
        if (!sys_rst_n1) begin
            state     <= IDLE;
            popped    <= '0;
            sent      <= '0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= rd_en;
            if (rd_en) begin
                popped <= popped + 1'b1;
            end
            if (xfer) begin
                sent <= sent + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (fifo_data_num >= THRESH) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.burst_ack) begin
                        state  <= XFER;
                        popped <= '0;
                        sent   <= '0;
                    end
                end
                XFER: begin
                    if (xfer && (sent == LAST - 1'b1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk1 or negedge sys_rst_n1) begin
        if (!sys_rst_n1) begin
            err_underrun <= 1'b0;
        end else if (fifo_underrun || (rd_en && fifo_empty)) begin
            err_underrun <= 1'b1;
        end
    end

    rd_skid_buf #(.DW(DW)) u_skid (
        .clk       (sys_clk1),
        .rst_n     (sys_rst_n1),
        .push      (in_flight),
        .push_data (rd_data),
        .pop       (xfer),
        .head_data (head_data),
        .count     (skid_count)
    );

    assign bus.burst_req      = (state == REQ);
    assign bus.wr_burst_valid = out_valid;
    assign bus.wr_burst_data  = head_data;
    assign busy               = (state != IDLE);

`ifdef FIFO_BURST_RD_STAT_EN
    always_ff @(posedge sys_clk1 or negedge sys_rst_n1) begin
        if (!sys_rst_n1) begin
            burst_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (state == DONE) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (out_valid && !bus.wr_burst_ready) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`else
    assign burst_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;
    import fifo_burst_rd_pkg::*;

    localparam int BL = 8;
    localparam int DW = 16;
    localparam int CW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_underrun = 1'b0;
    logic          force_empty = 1'b0;
    logic          fifo_empty;
    logic [CW-1:0] fifo_data_num;
    logic [DW-1:0] rd_data = '0;
    logic          rd_en;
    logic          busy;
    logic          err_underrun;
    logic [31:0]   burst_cnt;
    logic [31:0]   stall_cnt;

    fifo_burst_reader_if #(.DW(DW)) bus ();

    logic [DW-1:0] mem [256];
    int wptr = 0;
    int rptr = 0;
    int total = 0;
    int bad = 0;
    int stalls_exp = 0;
    logic [DW-1:0] got [$];

    always #5 clk = ~clk;

    // FIFO model: word at position p holds 16'hA000 + p
    assign fifo_empty    = (wptr == rptr) || force_empty;
    assign fifo_data_num = CW'(wptr - rptr);

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rptr % 256];
            rptr    <= rptr + 1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && bus.wr_burst_valid && bus.wr_burst_ready) begin
            got.push_back(bus.wr_burst_data);
        end
    end

    fifo_burst_reader #(.BURST_LEN(BL), .DW(DW), .CW(CW)) dut (
        .sys_clk1      (clk),
        .sys_rst_n1    (rst_n),
        .fifo_empty    (fifo_empty),
        .fifo_underrun (fifo_underrun),
        .fifo_data_num (fifo_data_num),
        .rd_data       (rd_data),
        .rd_en         (rd_en),
        .bus           (bus),
        .busy          (busy),
        .err_underrun  (err_underrun),
        .burst_cnt     (burst_cnt),
        .stall_cnt     (stall_cnt)
    );

    function automatic logic [31:0] stat_exp(input int v);
`ifdef FIFO_BURST_RD_STAT_EN
        return 32'(v);
`else
        return 32'(v) & 32'h0;
`endif
    endfunction

    function automatic logic [DW-1:0] word_at(input int p);
        return 16'hA000 + 16'(p);
    endfunction

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wptr % 256] = word_at(wptr);
            wptr++;
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (bus.burst_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // returns at the negedge right after the edge that sampled burst_ack
    task automatic pulse_ack();
        @(negedge clk);
        bus.burst_ack = 1'b1;
        @(negedge clk);
        bus.burst_ack = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.burst_ack = 1'b0;
        bus.wr_burst_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        total++; if (bus.burst_req !== 1'b0) begin bad++; $display("FAIL reset_burst_req: got %b want 0", bus.burst_req); end
        total++; if (bus.wr_burst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.wr_burst_valid); end
        total++; if (bus.wr_burst_data !== 16'h0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.wr_burst_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (err_underrun !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_underrun); end
        total++; if (burst_cnt !== 32'd0) begin bad++; $display("FAIL reset_burst_cnt: got %0d want 0", burst_cnt); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_threshold();
        fill(7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            total++; if (bus.burst_req !== 1'b0) begin bad++; $display("FAIL thresh_below: got %b want 0", bus.burst_req); end
        end
        @(negedge clk);
        fill(1);
        #1;
        total++; if (bus.burst_req !== 1'b0) begin bad++; $display("FAIL thresh_same_cycle: got %b want 0", bus.burst_req); end
        @(negedge clk); #1;
        total++; if (bus.burst_req !== 1'b1) begin bad++; $display("FAIL thresh_req: got %b want 1", bus.burst_req); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL thresh_busy: got %b want 1", busy); end
    endtask

    // entered with burst_req high; ack two cycles later, ready held high
    task automatic test_basic_burst();
        int  base;
        bit  e_rd, e_v, e_busy;
        base = rptr;
        got.delete();
        bus.wr_burst_ready = 1'b1;
        @(negedge clk);
        pulse_ack();
        for (int j = 0; j < 12; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            e_rd   = (j <= 7);
            e_v    = (j >= 2) && (j <= 9);
            e_busy = (j <= 10);
            total++; if (rd_en !== e_rd) begin bad++; $display("FAIL basic_rd_en[%0d]: got %b want %b", j, rd_en, e_rd); end
            total++; if (bus.wr_burst_valid !== e_v) begin bad++; $display("FAIL basic_valid[%0d]: got %b want %b", j, bus.wr_burst_valid, e_v); end
            total++; if (busy !== e_busy) begin bad++; $display("FAIL basic_busy[%0d]: got %b want %b", j, busy, e_busy); end
            if (e_v) begin
                total++;
                if (bus.wr_burst_data !== word_at(base + j - 2)) begin
                    bad++; $display("FAIL basic_data[%0d]: got %h want %h", j, bus.wr_burst_data, word_at(base + j - 2));
                end
            end
        end
        total++; if (got.size() != BL) begin bad++; $display("FAIL basic_count: got %0d want %0d", got.size(), BL); end
        total++; if (burst_cnt !== stat_exp(1)) begin bad++; $display("FAIL basic_burst_cnt: got %0d want %0d", burst_cnt, stat_exp(1)); end
        total++; if (err_underrun !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", err_underrun); end
    endtask

    task automatic test_ready_toggle();
        int base, nwords, c;
        bit ok, prev_v, prev_r;
        logic [DW-1:0] prev_d;
        logic [3:0] pat;
        pat = 4'b1001;
        base = rptr;
        nwords = 0;
        c = 0;
        prev_v = 1'b0;
        prev_r = 1'b1;
        prev_d = '0;
        got.delete();
        fill(BL);
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL toggle_req_timeout: got 0 want 1"); end
        pulse_ack();
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (i > 0) @(negedge clk);
            bus.wr_burst_ready = pat[c % 4];
            c++;
            #1;
            if (prev_v && !prev_r) begin
                total++;
                if (bus.wr_burst_valid !== 1'b1 || bus.wr_burst_data !== prev_d) begin
                    bad++; $display("FAIL toggle_hold: got v=%b d=%h want v=1 d=%h", bus.wr_burst_valid, bus.wr_burst_data, prev_d);
                end
            end
            if (bus.wr_burst_valid && !bus.wr_burst_ready) stalls_exp++;
            if (bus.wr_burst_valid && bus.wr_burst_ready) begin
                total++;
                if (bus.wr_burst_data !== word_at(base + nwords)) begin
                    bad++; $display("FAIL toggle_data[%0d]: got %h want %h", nwords, bus.wr_burst_data, word_at(base + nwords));
                end
                nwords++;
            end
            prev_v = bus.wr_burst_valid;
            prev_r = bus.wr_burst_ready;
            prev_d = bus.wr_burst_data;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        bus.wr_burst_ready = 1'b1;
        total++; if (!ok) begin bad++; $display("FAIL toggle_idle_timeout: got busy=1 want 0"); end
        total++; if (nwords != BL || got.size() != BL) begin bad++; $display("FAIL toggle_count: got %0d/%0d want %0d", nwords, got.size(), BL); end
        total++; if (stall_cnt !== stat_exp(stalls_exp)) begin bad++; $display("FAIL toggle_stall_cnt: got %0d want %0d", stall_cnt, stat_exp(stalls_exp)); end
        total++; if (burst_cnt !== stat_exp(2)) begin bad++; $display("FAIL toggle_burst_cnt: got %0d want %0d", burst_cnt, stat_exp(2)); end
    endtask

    task automatic test_empty_stall();
        int base;
        bit ok;
        base = rptr;
        got.delete();
        fill(BL);
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL empty_req_timeout: got 0 want 1"); end
        pulse_ack();
        ok = 1'b0;
        for (int j = 0; j < 60; j++) begin
            if (j > 0) @(negedge clk);
            force_empty = (j >= 2) && (j <= 4);
            #1;
            if (j >= 2 && j <= 4) begin
                total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL empty_rd_en[%0d]: got %b want 0", j, rd_en); end
            end
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        force_empty = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL empty_idle_timeout: got busy=1 want 0"); end
        total++; if (got.size() != BL) begin bad++; $display("FAIL empty_count: got %0d want %0d", got.size(), BL); end
        for (int i = 0; i < got.size(); i++) begin
            total++; if (got[i] !== word_at(base + i)) begin bad++; $display("FAIL empty_data[%0d]: got %h want %h", i, got[i], word_at(base + i)); end
        end
        total++; if (err_underrun !== 1'b0) begin bad++; $display("FAIL empty_err: got %b want 0", err_underrun); end
        total++; if (burst_cnt !== stat_exp(3)) begin bad++; $display("FAIL empty_burst_cnt: got %0d want %0d", burst_cnt, stat_exp(3)); end
    endtask

    task automatic test_underrun();
        bit ok;
        @(negedge clk);
        fifo_underrun = 1'b1;
        @(negedge clk);
        fifo_underrun = 1'b0;
        #1;
        total++; if (err_underrun !== 1'b1) begin bad++; $display("FAIL underrun_set: got %b want 1", err_underrun); end
        got.delete();
        fill(BL);
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL underrun_req_timeout: got 0 want 1"); end
        pulse_ack();
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL underrun_idle_timeout: got busy=1 want 0"); end
        total++; if (got.size() != BL) begin bad++; $display("FAIL underrun_count: got %0d want %0d", got.size(), BL); end
        total++; if (err_underrun !== 1'b1) begin bad++; $display("FAIL underrun_sticky: got %b want 1", err_underrun); end
        total++; if (burst_cnt !== stat_exp(4)) begin bad++; $display("FAIL underrun_burst_cnt: got %0d want %0d", burst_cnt, stat_exp(4)); end
    endtask

    task automatic test_reset_mid_burst();
        int base;
        bit ok;
        logic [DW+36-1:0] snap;
        got.delete();
        fill(BL);
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL midrst_req_timeout: got 0 want 1"); end
        pulse_ack();
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (got.size() >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (!ok) begin bad++; $display("FAIL midrst_words_timeout: got %0d want 3", got.size()); end
        #2 rst_n = 1'b0;
        #1;
        snap = {rd_en, bus.burst_req, bus.wr_burst_valid, busy, bus.wr_burst_data, burst_cnt};
        total++; if (snap !== '0) begin bad++; $display("FAIL midrst_outputs: got %h want 0", snap); end
        total++; if (err_underrun !== 1'b0) begin bad++; $display("FAIL midrst_err: got %b want 0", err_underrun); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL midrst_stall_cnt: got %0d want 0", stall_cnt); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = rptr;
        got.delete();
        fill(BL);
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL midrst_req2_timeout: got 0 want 1"); end
        pulse_ack();
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL midrst_idle_timeout: got busy=1 want 0"); end
        total++; if (got.size() != BL) begin bad++; $display("FAIL midrst_count: got %0d want %0d", got.size(), BL); end
        for (int i = 0; i < got.size(); i++) begin
            total++; if (got[i] !== word_at(base + i)) begin bad++; $display("FAIL midrst_data[%0d]: got %h want %h", i, got[i], word_at(base + i)); end
        end
        total++; if (burst_cnt !== stat_exp(1)) begin bad++; $display("FAIL midrst_burst_cnt: got %0d want %0d", burst_cnt, stat_exp(1)); end
    endtask

    initial begin
        bus.burst_ack = 1'b0;
        bus.wr_burst_ready = 1'b1;
        test_reset();
        test_threshold();
        test_basic_burst();
        test_ready_toggle();
        test_empty_stall();
        test_underrun();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
